// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter: FSM state encoding,
// requester tag constants and a small round-robin helper.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic TAG_IF = 1'b0;
    localparam logic TAG_D  = 1'b1;

    // The requester that was not served last gets the next tie.
    function automatic logic other_tag(input logic tag);
        return (tag == TAG_IF) ? TAG_D : TAG_IF;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_arbiter_2.sv
// Combinational two-way round-robin grant between instruction fetch and data.
// A lone requester always wins; on a tie the one not granted last wins.
module rr_arbiter_2
    import mem_port_arbiter_pkg::*;
(
    input  logic req_if,
    input  logic req_d,
    input  logic last_grant,
    output logic grant_valid,
    output logic grant_tag
);

    // Pick the winner from the current requests and the previous grant.
    always_comb begin
        grant_valid = req_if | req_d;
        if (req_if && req_d) begin
            grant_tag = other_tag(last_grant);
        end else if (req_d) begin
            grant_tag = TAG_D;
        end else begin
            grant_tag = TAG_IF;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported fixed-latency memory between instruction fetch and
// data load/store. The winning request is latched and held on the memory port
// for LATENCY cycles; read data returns with a one-cycle valid pulse.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int LATENCY = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ready,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ready,
    output logic              d_valid,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int               CNT_W    = $clog2(LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    state_t            state_r, state_nxt;
    logic [CNT_W-1:0]  cnt_r, cnt_nxt;
    logic              last_grant_r, last_nxt;
    logic              tag_r, tag_nxt;
    logic              we_r, we_nxt;
    logic [ADDR_W-1:0] addr_r, addr_nxt;
    logic [DATA_W-1:0] wdata_r, wdata_nxt;
    logic [DATA_W-1:0] if_rdata_r, if_rdata_nxt;
    logic [DATA_W-1:0] d_rdata_r, d_rdata_nxt;
    logic              mem_we_r, mem_we_nxt;
    logic              if_valid_r, if_valid_nxt;
    logic              d_valid_r, d_valid_nxt;
    logic              grant_en_s;
    logic              grant_valid_s;
    logic              grant_tag_s;
    logic              busy_last_s;

    rr_arbiter_2 u_rr (
        .req_if      (if_req),
        .req_d       (d_req),
        .last_grant  (last_grant_r),
        .grant_valid (grant_valid_s),
        .grant_tag   (grant_tag_s)
    );

    // Next-state, latch and output-pulse computation for the transaction FSM.
    always_comb begin
        state_nxt    = state_r;
        cnt_nxt      = cnt_r;
        last_nxt     = last_grant_r;
        tag_nxt      = tag_r;
        we_nxt       = we_r;
        addr_nxt     = addr_r;
        wdata_nxt    = wdata_r;
        if_rdata_nxt = if_rdata_r;
        d_rdata_nxt  = d_rdata_r;
        grant_en_s   = 1'b0;
        busy_last_s  = (state_r == ST_BUSY) && (cnt_r == CNT_ZERO);

        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (grant_valid_s) begin
                    grant_en_s = 1'b1;
                    state_nxt  = ST_BUSY;
                    cnt_nxt    = CNT_INIT;
                    tag_nxt    = grant_tag_s;
                    last_nxt   = grant_tag_s;
                    if (grant_tag_s == TAG_D) begin
                        addr_nxt  = d_addr;
                        we_nxt    = d_we;
                        wdata_nxt = d_wdata;
                    end else begin
                        addr_nxt  = if_addr;
                        we_nxt    = 1'b0;
                    end
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (cnt_r != CNT_ZERO) begin
                    cnt_nxt = cnt_r - CNT_ONE;
                end else begin
                    state_nxt = ST_DONE;
                    if (!we_r) begin
                        if (tag_r == TAG_D) begin
                            d_rdata_nxt = mem_rdata;
                        end else begin
                            if_rdata_nxt = mem_rdata;
                        end
                    end else begin
                        d_rdata_nxt = d_rdata_r;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        // Write strobe is registered so it lands exactly on the final BUSY cycle.
        mem_we_nxt   = (state_nxt == ST_BUSY) && (cnt_nxt == CNT_ZERO) && we_nxt;
        if_valid_nxt = busy_last_s && (tag_r == TAG_IF);
        d_valid_nxt  = busy_last_s && (tag_r == TAG_D);
    end

    // State, latches and registered outputs; reset aborts any transaction.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            cnt_r        <= CNT_ZERO;
            last_grant_r <= TAG_IF;
            tag_r        <= TAG_IF;
            we_r         <= 1'b0;
            addr_r       <= {ADDR_W{1'b0}};
            wdata_r      <= {DATA_W{1'b0}};
            if_rdata_r   <= {DATA_W{1'b0}};
            d_rdata_r    <= {DATA_W{1'b0}};
            mem_we_r     <= 1'b0;
            if_valid_r   <= 1'b0;
            d_valid_r    <= 1'b0;
        end else begin
            state_r      <= state_nxt;
            cnt_r        <= cnt_nxt;
            last_grant_r <= last_nxt;
            tag_r        <= tag_nxt;
            we_r         <= we_nxt;
            addr_r       <= addr_nxt;
            wdata_r      <= wdata_nxt;
            if_rdata_r   <= if_rdata_nxt;
            d_rdata_r    <= d_rdata_nxt;
            mem_we_r     <= mem_we_nxt;
            if_valid_r   <= if_valid_nxt;
            d_valid_r    <= d_valid_nxt;
        end
    end

    // Ready is the same-cycle acceptance handshake, so it comes from the grant.
    assign if_ready  = grant_en_s && (grant_tag_s == TAG_IF) && !reset;
    assign d_ready   = grant_en_s && (grant_tag_s == TAG_D) && !reset;
    assign if_valid  = if_valid_r;
    assign d_valid   = d_valid_r;
    assign if_rdata  = if_rdata_r;
    assign d_rdata   = d_rdata_r;
    assign mem_addr  = addr_r;
    assign mem_we    = mem_we_r;
    assign mem_wdata = wdata_r;

endmodule
